// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, fixed-rate bit timing and a
// single-entry output register with a valid/ready handshake.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic             sync_1;
  logic             rxd_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             half_hit;
  logic             bit_hit;
  logic             stop_ok;
  logic             stop_bad;

  assign half_hit = (cnt == CNT_W'(HALF_BIT - 1));
  assign bit_hit  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign stop_ok  = (state == STOP) && bit_hit && rxd_s;
  assign stop_bad = (state == STOP) && bit_hit && !rxd_s;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      sync_1 <= rxd_i;
      rxd_s  <= sync_1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (half_hit) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxd_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_hit) begin
            cnt   <= '0;
            shift <= {rxd_s, shift[7:1]};
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_hit) begin
            cnt   <= '0;
            state <= rxd_s ? IDLE : BREAK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // A line held low after a bad stop bit must go high before a new start is accepted.
        BREAK: begin
          if (rxd_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_o   <= 8'h00;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_bad;
      overrun_o   <= 1'b0;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      // A byte arriving on the same edge as a transfer replaces the consumed one.
      if (stop_ok) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o  <= shift;
          rx_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule
